// File: rtl/prio_arbiter.sv
// Registered N-way priority arbiter (fixed or round-robin) with a valid/ready grant output.
// Optional grant locking is compiled in with `define PRIO_ARB_LOCK_EN.
module prio_arbiter #(
   parameter  int N   = 8,
   localparam int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic           mode,
`ifdef PRIO_ARB_LOCK_EN
   input  logic           lock,
`endif
   input  logic           gnt_ready,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_idx,
   output logic [N-1:0]   gnt_onehot
);

`ifdef PRIO_ARB_LOCK_EN
   typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
`else
   typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

   state_t         state, state_n;
   logic [IDW-1:0] ptr, ptr_n;
   logic [IDW-1:0] idx_n;
   logic [N-1:0]   onehot_n;
   logic [IDW-1:0] arb_ptr;
   logic           arb;

   function automatic logic [IDW-1:0] dec_wrap(input logic [IDW-1:0] k);
      dec_wrap = (k == '0) ? IDW'(N - 1) : k - IDW'(1);
   endfunction

   // Last hit wins, so the highest set index is returned.
   function automatic logic [IDW-1:0] fixed_pick(input logic [N-1:0] r);
      fixed_pick = '0;
      for (int i = 0; i < N; i++)
         if ((r & (N'(1) << i)) != '0) fixed_pick = IDW'(i);
   endfunction

   // Search p, p-1, ..., 0, N-1, ... using an explicit wrap so non-power-of-two N works.
   function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
      logic found;
      int   k;
      rr_pick = '0;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i <= int'(p)) k = int'(p) - i;
         else              k = int'(p) + N - i;
         if (!found && ((r & (N'(1) << k)) != '0)) begin
            rr_pick = IDW'(k);
            found   = 1'b1;
         end
      end
   endfunction

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      idx_n    = gnt_idx;
      onehot_n = gnt_onehot;
      arb      = 1'b0;
      arb_ptr  = ptr;
      case (state)
         IDLE: arb = 1'b1;
         GRANT: begin
            if (gnt_ready) begin
`ifdef PRIO_ARB_LOCK_EN
               if (lock) begin
                  state_n = LOCK;
               end else
`endif
               begin
                  // Arbitrate against the pointer the accept is about to write.
                  ptr_n   = dec_wrap(gnt_idx);
                  arb_ptr = ptr_n;
                  arb     = 1'b1;
               end
            end
         end
`ifdef PRIO_ARB_LOCK_EN
         LOCK: begin
            if (!lock) begin
               ptr_n   = dec_wrap(gnt_idx);
               arb_ptr = ptr_n;
               arb     = 1'b1;
            end
         end
`endif
         default: state_n = IDLE;
      endcase

      if (arb) begin
         if (req != '0) begin
            state_n  = GRANT;
            idx_n    = mode ? rr_pick(req, arb_ptr) : fixed_pick(req);
            onehot_n = N'(1) << idx_n;
         end else begin
            state_n  = IDLE;
            idx_n    = '0;
            onehot_n = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= IDW'(N - 1);
         gnt_idx    <= '0;
         gnt_onehot <= '0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         gnt_idx    <= idx_n;
         gnt_onehot <= onehot_n;
      end
   end

   assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model; lock scenarios run when PRIO_ARB_LOCK_EN is defined.
module tb_prio_arbiter;
   localparam int N   = 8;
   localparam int IDW = 3;
`ifdef PRIO_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic           mode = 1'b0;
   logic           gnt_ready = 1'b0;
   logic           lock = 1'b0;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_idx;
   logic [N-1:0]   gnt_onehot;

   typedef struct packed {
      logic           v;
      logic [IDW-1:0] idx;
      logic [N-1:0]   oh;
   } exp_t;

   exp_t sbq[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Model state: 0 = idle, 1 = granting, 2 = locked
   int m_state = 0;
   int m_idx   = 0;
   int m_ptr   = N - 1;

   prio_arbiter #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mode      (mode),
`ifdef PRIO_ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt_ready (gnt_ready),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .gnt_onehot(gnt_onehot)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] r, input logic md, input int p);
      int w;
      w = -1;
      if (!md) begin
         for (int i = N - 1; i >= 0; i--)
            if (w < 0 && (r & (N'(1) << i)) != '0) w = i;
      end else begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (p - i + N) % N;
            if (w < 0 && (r & (N'(1) << k)) != '0) w = k;
         end
      end
      return w;
   endfunction

   task automatic model_step();
      bit   do_arb;
      exp_t e;
      do_arb = 1'b0;
      if (!rst_n) begin
         m_state = 0;
         m_idx   = 0;
         m_ptr   = N - 1;
      end else begin
         if (m_state == 0) begin
            do_arb = 1'b1;
         end else if (m_state == 1 && gnt_ready) begin
            if (LOCK_EN && lock) begin
               m_state = 2;
            end else begin
               m_ptr  = (m_idx == 0) ? N - 1 : m_idx - 1;
               do_arb = 1'b1;
            end
         end else if (m_state == 2 && !lock) begin
            m_ptr  = (m_idx == 0) ? N - 1 : m_idx - 1;
            do_arb = 1'b1;
         end
         if (do_arb) begin
            if (req != '0) begin
               m_idx   = pick(req, mode, m_ptr);
               m_state = 1;
            end else begin
               m_idx   = 0;
               m_state = 0;
            end
         end
      end
      e.v   = (m_state == 1);
      e.idx = IDW'(m_idx);
      e.oh  = (m_state == 0) ? '0 : (N'(1) << m_idx);
      sbq.push_back(e);
   endtask

   task automatic step(input logic [N-1:0] r, input logic md, input logic rdy,
                       input logic lk, input logic rn);
      @(negedge clk);
      req       = r;
      mode      = md;
      gnt_ready = rdy;
      lock      = lk;
      rst_n     = rn;
      model_step();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_now(input string name, input int v, input int idx);
      @(posedge clk);
      #2;
      chk({name, "_valid"}, int'(gnt_valid), v);
      chk({name, "_idx"}, int'(gnt_idx), idx);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (gnt_valid !== e.v || gnt_idx !== e.idx || gnt_onehot !== e.oh) begin
               miscompares++;
               $display("FAIL scoreboard t=%0t: got v=%0b idx=%0d oh=%h, expected v=%0b idx=%0d oh=%h",
                        $time, gnt_valid, gnt_idx, gnt_onehot, e.v, e.idx, e.oh);
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset held with all requests active
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("reset_valid", int'(gnt_valid), 0);
      chk("reset_onehot", int'(gnt_onehot), 0);
      chk("reset_idx", int'(gnt_idx), 0);
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_now("first_grant", 1, 7);
      chk("first_onehot", int'(gnt_onehot), 8'h80);

      // Fixed priority starves lower requesters
      for (int i = 0; i < 6; i++) step(8'b0010_0110, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_now("fixed_prio", 1, 5);

      // Round-robin rotation from a fresh pointer
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'b1001_0001, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(8'b1001_0001, 1'b1, 1'b1, 1'b0, 1'b1);
      expect_now("rr_rotate", 1, 0);

      // Grant held stable while not accepted, even when the winner drops
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(8'h0C, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_now("hold", 1, 3);
      step(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
      expect_now("after_accept", 1, 0);

      // Asynchronous reset in the middle of a grant
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rst_drop_valid", int'(gnt_valid), 0);
      chk("rst_drop_onehot", int'(gnt_onehot), 0);
      step(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_now("post_rst", 1, 4);

      // gnt_ready while idle must not disturb anything
      step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_now("idle_ready", 0, 0);

`ifdef PRIO_ARB_LOCK_EN
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
      step(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1);
      step(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
      step(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1);
      expect_now("locked", 0, 2);
      step(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_now("unlock", 1, 1);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] r;
         r = N'($urandom);
         if ($urandom_range(0, 7) == 0) r = '0;
         step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              LOCK_EN ? 1'($urandom_range(0, 3) == 0) : 1'b0,
              1'($urandom_range(0, 99) != 0));
      end

      step(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #3;
      chk("sb_drain", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
